// File: rtl/jpeg_bit_packer.sv
// JPEG entropy bit packer: FIFO of (elen, edata) code words into an MSB-first
// byte stream with 0xFF->0xFF00 stuffing, 1-bit pad and EOI on flush.
// Ports: clk, rst (sync, active-high); elen/edata code word in; ready back-
// pressure to the encoders; flush end-of-scan pulse; obyte/ovalid/oready
// byte out; busy, done (EOI accepted), overflow (sticky error).
module jpeg_bit_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  elen,
  input  logic [31:0] edata,
  output logic        ready,
  input  logic        flush,
  output logic [7:0]  obyte,
  output logic        ovalid,
  input  logic        oready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] SLACK_W = (AW+1)'(SLACK);

  typedef enum logic [2:0] {RUN, STUFF, PAD, EOI1, EOI2} state_t;

  logic [5:0]    mem_len  [FIFO_DEPTH];
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   flush_cnt;
  logic [63:0]   acc;
  logic [6:0]    fill;
  state_t        state;
  logic          stuff_eoi;
  logic          eoi_loaded;
  logic          flush_pend;

  logic          ofree;
  logic          full;
  logic          push;
  logic          bad_word;
  logic [5:0]    head_len;
  logic [31:0]   head_data;
  logic          extract;
  logic [6:0]    fill_ex;
  logic [63:0]   acc_ex;
  logic          pop_ok;
  logic          pop;
  logic [7:0]    fit_sum;
  logic [31:0]   mask;
  logic [6:0]    sh;
  logic [63:0]   word;
  logic [63:0]   acc_nx;
  logic [6:0]    fill_nx;
  logic [AW:0]   count_nx;
  logic [AW:0]   free_nx;
  logic          flush_take;
  logic          eoi_acc;
  logic          fp_nx;
  logic [7:0]    pad_byte;

  assign ofree     = !ovalid || oready;
  assign full      = (count == DEPTH_W);
  assign push      = (elen != 6'd0) && (elen <= 6'd32) && !full;
  assign bad_word  = (elen > 6'd32) || ((elen != 6'd0) && full);
  assign head_len  = mem_len[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  assign extract = (state == RUN) && ofree && (fill >= 7'd8);
  assign fill_ex = extract ? fill - 7'd8 : fill;
  assign acc_ex  = extract ? {acc[55:0], 8'h00} : acc;

  // Words queued behind a flush must wait until after the EOI, so only the
  // flush_cnt words that were present at flush time may be popped.
  assign pop_ok  = (state == RUN) || ((state == STUFF) && !stuff_eoi);
  assign fit_sum = {1'b0, fill_ex} + {2'b00, head_len};
  assign pop     = (count != '0) && pop_ok &&
                   (!flush_pend || (flush_cnt != '0)) &&
                   (fit_sum <= 8'd64);

  assign mask    = (32'd1 << head_len) - 32'd1;
  assign sh      = 7'd64 - fill_ex - {1'b0, head_len};
  assign word    = {32'd0, head_data & mask} << sh;
  assign acc_nx  = pop ? (acc_ex | word) : acc_ex;
  assign fill_nx = pop ? fill_ex + {1'b0, head_len} : fill_ex;

  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
  assign free_nx  = DEPTH_W - count_nx;

  assign flush_take = flush && !flush_pend;
  assign eoi_acc    = (state == EOI2) && eoi_loaded && ovalid && oready;
  assign fp_nx      = eoi_acc ? 1'b0 : (flush_pend || flush);

  // Valid bits sit at the top of acc and everything below is zero.
  assign pad_byte = acc[63:56] | (8'hFF >> fill[2:0]);

  assign busy = (count != '0) || (fill != 7'd0) || flush_pend || ovalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_cnt  <= '0;
      acc        <= '0;
      fill       <= '0;
      state      <= RUN;
      stuff_eoi  <= 1'b0;
      eoi_loaded <= 1'b0;
      flush_pend <= 1'b0;
      obyte      <= 8'h00;
      ovalid     <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      ready      <= 1'b0;
    end else begin
      if (push) begin
        mem_len[wr_ptr]  <= elen;
        mem_data[wr_ptr] <= edata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      acc   <= acc_nx;
      fill  <= fill_nx;

      if (bad_word) overflow <= 1'b1;

      if (flush_take) flush_cnt <= count_nx;
      else if (flush_pend && pop) flush_cnt <= flush_cnt - 1'b1;

      flush_pend <= fp_nx;
      ready      <= (free_nx >= SLACK_W) && !fp_nx;
      done       <= 1'b0;

      if (ovalid && oready) ovalid <= 1'b0;

      unique case (state)
        RUN: begin
          if (extract) begin
            obyte  <= acc[63:56];
            ovalid <= 1'b1;
            if (acc[63:56] == 8'hFF) begin
              state     <= STUFF;
              stuff_eoi <= 1'b0;
            end
          end else if (flush_pend && (flush_cnt == '0) &&
                       (fill < 7'd8)) begin
            state <= (fill != 7'd0) ? PAD : EOI1;
          end
        end
        STUFF: begin
          if (ofree) begin
            obyte  <= 8'h00;
            ovalid <= 1'b1;
            state  <= stuff_eoi ? EOI1 : RUN;
          end
        end
        PAD: begin
          if (ofree) begin
            obyte  <= pad_byte;
            ovalid <= 1'b1;
            acc    <= '0;
            fill   <= '0;
            if (pad_byte == 8'hFF) begin
              state     <= STUFF;
              stuff_eoi <= 1'b1;
            end else begin
              state <= EOI1;
            end
          end
        end
        EOI1: begin
          if (ofree) begin
            obyte      <= 8'hFF;
            ovalid     <= 1'b1;
            eoi_loaded <= 1'b0;
            state      <= EOI2;
          end
        end
        EOI2: begin
          if (!eoi_loaded) begin
            if (ofree) begin
              obyte      <= 8'hD9;
              ovalid     <= 1'b1;
              eoi_loaded <= 1'b1;
            end
          end else if (eoi_acc) begin
            done       <= 1'b1;
            eoi_loaded <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed self-checking bench for jpeg_bit_packer.
// Each task drives one scenario and checks accepted bytes and flags inline.
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  elen = '0;
  logic [31:0] edata = '0;
  logic        ready;
  logic        flush = 1'b0;
  logic [7:0]  obyte;
  logic        ovalid;
  logic        oready = 1'b1;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] got[$];
  int done_cnt = 0;
  int done_at = -1;

  always #5 clk = ~clk;

  jpeg_bit_packer #(.FIFO_DEPTH(16), .SLACK(6)) dut (
    .clk(clk), .rst(rst), .elen(elen), .edata(edata), .ready(ready),
    .flush(flush), .obyte(obyte), .ovalid(ovalid), .oready(oready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always @(posedge clk) begin
    if (done) begin
      done_cnt++;
      done_at = got.size();
    end
    if (!rst && ovalid && oready) got.push_back(obyte);
  end

  task automatic send(input logic [5:0] l, input logic [31:0] d,
                      input logic f);
    elen = l;
    edata = d;
    flush = f;
    @(negedge clk);
    elen = '0;
    edata = '0;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      failures++;
      $display("FAIL done_timeout: no done after %0d cycles", maxc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    oready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ovalid !== 1'b0) begin
      failures++; $display("FAIL rst_ovalid got=%b exp=0", ovalid);
    end
    checks++;
    if (obyte !== 8'h00) begin
      failures++; $display("FAIL rst_obyte got=%h exp=00", obyte);
    end
    checks++;
    if ({done, overflow, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b%b%b exp=000", done, overflow, busy);
    end
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL rst_ready got=%b exp=0", ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL post_rst_ready got=%b exp=1", ready);
    end
  endtask

  task automatic test_pack();
    logic [7:0] exp_b[$];
    exp_b = '{8'hB4, 8'h7F, 8'hFF, 8'hD9};
    got.delete();
    done_at = -1;
    send(6'd11, 32'h5A3, 1'b0);
    send(6'd0, 32'h0, 1'b1);
    wait_done(100);
    checks++;
    if (got.size() != exp_b.size()) begin
      failures++;
      $display("FAIL pack_len got=%0d exp=%0d", got.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL pack_byte%0d got=%h exp=%h", i, got[i], exp_b[i]);
      end
    end
    checks++;
    if (done_at != 4) begin
      failures++; $display("FAIL pack_done_pos got=%0d exp=4", done_at);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL pack_overflow got=%b exp=0", overflow);
    end
  endtask

  task automatic test_stuff();
    logic [7:0] exp_b[$];
    exp_b = '{8'hFF, 8'h00, 8'h12, 8'hFF, 8'hD9};
    got.delete();
    send(6'd16, 32'hFF12, 1'b1);
    wait_done(100);
    checks++;
    if (got.size() != exp_b.size()) begin
      failures++;
      $display("FAIL stuff_len got=%0d exp=%0d", got.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL stuff_byte%0d got=%h exp=%h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_aligned();
    logic [7:0] exp_b[$];
    logic [5:0] lens[2];
    logic [31:0] dats[2];
    exp_b = '{8'hFF, 8'h00, 8'hFF, 8'hD9};
    lens[0] = 6'd8; dats[0] = 32'hFF;
    lens[1] = 6'd1; dats[1] = 32'h1;
    for (int k = 0; k < 2; k++) begin
      got.delete();
      send(lens[k], dats[k], 1'b1);
      wait_done(100);
      checks++;
      if (got.size() != exp_b.size()) begin
        failures++;
        $display("FAIL aligned%0d_len got=%0d exp=%0d", k, got.size(),
                 exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL aligned%0d_byte%0d got=%h exp=%h", k, i, got[i],
                   exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic [7:0] pat[4];
    int issued;
    int cyc;
    logic saw_low;
    pat[0] = 8'h01; pat[1] = 8'h23; pat[2] = 8'h45; pat[3] = 8'h67;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got.delete();
    oready = 1'b1;
    issued = 0;
    cyc = 0;
    saw_low = 1'b0;
    while (issued < 64 && cyc < 2000) begin
      if (ready) begin
        elen = 6'd32;
        edata = 32'h01234567;
        issued++;
      end else begin
        elen = 6'd0;
        saw_low = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    elen = 6'd0;
    cyc = 0;
    while (got.size() < 256 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (got.size() != 256) begin
      failures++; $display("FAIL tput_len got=%0d exp=256", got.size());
    end
    for (int i = 0; i < 256 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== pat[i % 4]) begin
        failures++;
        $display("FAIL tput_byte%0d got=%h exp=%h", i, got[i], pat[i % 4]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL tput_overflow got=%b exp=0", overflow);
    end
    checks++;
    if (saw_low !== 1'b1) begin
      failures++; $display("FAIL tput_ready_toggle got=%b exp=1", saw_low);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL tput_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    logic seen;
    int unstable;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    oready = 1'b0;
    held = 8'h00;
    seen = 1'b0;
    unstable = 0;
    for (int c = 0; c < 200; c++) begin
      elen = 6'd32;
      edata = 32'h89ABCDEF;
      @(negedge clk);
      if (ovalid) begin
        if (!seen) begin
          seen = 1'b1;
          held = obyte;
        end else if (obyte !== held) begin
          unstable++;
        end
      end
    end
    elen = 6'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (unstable != 0) begin
      failures++; $display("FAIL stall_stable got=%0d exp=0", unstable);
    end
    checks++;
    if (held !== 8'h89 || obyte !== 8'h89) begin
      failures++;
      $display("FAIL stall_obyte got=%h/%h exp=89", held, obyte);
    end
    checks++;
    if (ovalid !== 1'b1) begin
      failures++; $display("FAIL stall_ovalid got=%b exp=1", ovalid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL stall_overflow got=%b exp=1", overflow);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL stall_busy got=%b exp=1", busy);
    end
  endtask

  task automatic test_midreset();
    logic [7:0] exp_b[$];
    exp_b = '{8'hA5, 8'hFF, 8'hD9};
    oready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    checks++;
    if ({ovalid, busy, overflow} !== 3'b000) begin
      failures++;
      $display("FAIL mid_rst_flags got=%b%b%b exp=000", ovalid, busy,
               overflow);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL mid_rst_ready got=%b exp=1", ready);
    end
    send(6'd8, 32'hA5, 1'b1);
    wait_done(100);
    checks++;
    if (got.size() != exp_b.size()) begin
      failures++;
      $display("FAIL mid_len got=%0d exp=%0d", got.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL mid_byte%0d got=%h exp=%h", i, got[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_stuff();
    test_aligned();
    test_throughput();
    test_stall();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
